cfg_chain_master: RTL and testbench
===================================

# cfg_chain_master

Drives the configuration daisy chain that threads through the synapse/dendrite/neuron array. Host software writes a full configuration image as NUM_WORDS words. The block then shifts the image bit-serially into the chain head, pulses the chain latch, and optionally returns the bits that fall out of the chain tail as readback words. The block sits beside the network top: its cfg_out port feeds the array's first cfg_in, and the array's last cfg_out returns into this block's cfg_in.

## Interface

Parameters:
- WORD_W, 16, configuration word width in bits.
- NUM_WORDS, 4, words per image; chain length CHAIN_LEN = WORD_W*NUM_WORDS bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  host write word valid.
- wr_ready  out  1  buffer can accept a word (high in IDLE while count < NUM_WORDS).
- wr_data  in  WORD_W  host write word.
- start  in  1  single-cycle request to shift the buffered image.
- busy  out  1  high in SHIFT, LATCH and DRAIN.
- done  out  1  one-cycle pulse at end of transaction.
- rd_valid  out  1  readback word valid.
- rd_ready  in  1  readback consumer ready.
- rd_data  out  WORD_W  readback word.
- cfg_out  config_if.master  —  chain head; drives data, shift, latch.
- cfg_in  config_if.slave  —  chain tail; block samples data only.

config_if carries data (1 bit), shift (1 bit) and latch (1 bit). The chain advances one bit on each clk edge where shift=1.

## Operation

- Buffer: NUM_WORDS x WORD_W registers plus a word count.
  - A write (wr_valid & wr_ready) stores wr_data at index count, then count increments.
  - Writes are ignored outside IDLE and when count == NUM_WORDS.
- States: IDLE, SHIFT, LATCH, DRAIN.
  - IDLE -> SHIFT: start=1 and count == NUM_WORDS. When count < NUM_WORDS, start is ignored and the state stays IDLE.
  - Start while busy is ignored.
  - SHIFT: CHAIN_LEN cycles with cfg_out.shift=1. A bit counter runs 0..CHAIN_LEN-1. cfg_out.data = word 0 MSB first, then word 1, …, ending with LSB of word NUM_WORDS-1.
  - SHIFT -> LATCH when the bit counter reaches CHAIN_LEN-1.
  - LATCH: one cycle with cfg_out.latch=1 and shift=0. Next state is DRAIN (readback compiled in) or IDLE with done=1 (readback compiled out).
  - DRAIN: presents readback words 0..NUM_WORDS-1 on rd_data with rd_valid=1.
    - Word advances on rd_valid & rd_ready.
    - When the last word is accepted: done=1 for that cycle, and the next state is IDLE.
- Readback capture: in each SHIFT cycle, cfg_in.data is sampled into a CHAIN_LEN-bit capture register.
  - First sampled bit = MSB of readback word 0; arrival order fills words MSB first.
  - The chain tail returns the previous image: a chain of exactly CHAIN_LEN bits yields readback = previously shifted image.
- Write buffer count clears to 0 on entering IDLE from LATCH/DRAIN. A new image must be written for every transaction.
- cfg_out.data = 0 whenever shift=0.

## Timing

- Reset values:
  - All outputs 0, except wr_ready = 1.
  - State IDLE; count = 0; bit counter = 0.
- start sampled high at edge t (buffer full):
  - cfg_out.shift=1 for cycles t+1 … t+CHAIN_LEN.
  - cfg_out.latch=1 at cycle t+CHAIN_LEN+1.
  - rd_valid first high at t+CHAIN_LEN+2 (readback) or done=1 at t+CHAIN_LEN+2 (no readback).
- rd_data and rd_valid are registered. They hold stable while rd_valid & !rd_ready.
  - With rd_ready tied high, DRAIN lasts exactly NUM_WORDS cycles.
- busy is high from t+1 until the cycle after done.
- wr_ready is 0 from t+1 until IDLE is re-entered.
- Simultaneous wr_valid and start in IDLE with count == NUM_WORDS-1: the write is accepted and start is ignored (count was not full when start was sampled).
- Reset mid-SHIFT/LATCH/DRAIN:
  - Next cycle shift=0, latch=0, rd_valid=0 and done=0.
  - Buffer count is cleared.
  - Latch is never issued for a partial shift.

## Configuration

- CFG_READBACK_EN defined: capture register, DRAIN state and the rd_* handshake are present.
- CFG_READBACK_EN undefined:
  - No capture register and no DRAIN state; LATCH goes directly to IDLE with done.
  - rd_valid and rd_data are tied to 0; rd_ready and cfg_in.data are ignored.

## Test plan

- Reset then idle: after reset, wr_ready=1, busy=0, and shift, latch, rd_valid and done are all 0. Start with empty buffer -> no shift for 10 cycles.
- Single image, WORD_W=16, NUM_WORDS=4:
  - Stimulus: write 0xA5A5, 0x0001, 0x8000, 0xFFFF; start.
  - Response: 64 shift cycles with data sequence 1010…, then latch exactly one cycle at t+65.
- Back-to-back readback, with a 64-bit shift-register model as the chain:
  - Stimulus: image A = {0x1234,0x5678,0x9ABC,0xDEF0}, then image B = {0x1111,0x2222,0x3333,0x4444}.
  - Response: readback of B's transaction = A in word order; readback of A's transaction = 0.
- Backpressure: during DRAIN, deassert rd_ready for 3 cycles on word 1 -> rd_data holds stable and words arrive in order 0..3. done fires on acceptance of word 3.
- Illegal requests:
  - Write when 4 words are already buffered -> rejected; buffer unchanged.
  - Start during SHIFT -> ignored; shift count stays exactly 64.
- Reset mid-shift: assert reset at shift cycle 20 -> shift=0 next cycle, no latch pulse, count=0, wr_ready=1.

Source files
------------

// File: rtl/cfg_chain_master_if.sv
// config_if: one hop of the configuration daisy chain.
//   data  - serial configuration bit
//   shift - chain advances one bit on each clk edge where shift=1
//   latch - one-cycle pulse that commits the shifted image
// master drives all three; slave (chain tail seen by the master) exposes data only.
interface config_if;
  logic data;
  logic shift;
  logic latch;

  modport master (output data, output shift, output latch);
  modport slave  (input data);
endinterface

// File: rtl/cfg_chain_master.sv
// cfg_chain_master: buffers a NUM_WORDS x WORD_W configuration image from the
// host, shifts it MSB-first (word 0 first) into the chain head, pulses latch,
// and optionally returns the bits leaving the chain tail as readback words.
//
// Optional feature macro: CFG_READBACK_EN (capture register, DRAIN state, rd_*).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   wr_valid/ready/data host image write (accepted in IDLE while not full)
//   start               request to shift the buffered (full) image
//   busy                high in SHIFT, LATCH and DRAIN
//   done                one-cycle end-of-transaction pulse
//   rd_valid/ready/data readback words (tied to 0 without CFG_READBACK_EN)
//   cfg_out             chain head (data, shift, latch)
//   cfg_in              chain tail (data sampled during SHIFT)
module cfg_chain_master #(
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  config_if.master          cfg_out,
  config_if.slave           cfg_in
);

  localparam int unsigned CHAIN_LEN = WORD_W * NUM_WORDS;
  localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int unsigned BIT_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WORD_W-1:0]  buf_q [NUM_WORDS];
  logic [WORD_W-1:0]  buf_d [NUM_WORDS];
  logic               shift_q, shift_d;
  logic               latch_q, latch_d;
  logic               data_q, data_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               wr_ready_q, wr_ready_d;
  logic [CHAIN_LEN-1:0] img;
  logic               wr_fire;

`ifdef CFG_READBACK_EN
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0]    rd_data_q, rd_data_d;

  // Word k of the captured stream; word 0 occupies the MSBs.
  function automatic logic [WORD_W-1:0] word_of(input logic [CHAIN_LEN-1:0] v,
                                                input logic [IDX_W-1:0] k);
    word_of = '0;
    for (int unsigned w = 0; w < NUM_WORDS; w++)
      if (IDX_W'(w) == k) word_of = v[(NUM_WORDS-1-w)*WORD_W +: WORD_W];
  endfunction
`endif

  assign wr_fire = wr_valid & wr_ready_q;

  // Flatten the buffer so the first bit to shift (word 0 MSB) is img[CHAIN_LEN-1].
  always_comb begin
    img = '0;
    for (int unsigned w = 0; w < NUM_WORDS; w++)
      img[(NUM_WORDS-1-w)*WORD_W +: WORD_W] = buf_q[w];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    bit_d   = bit_q;
    buf_d   = buf_q;
    shift_d = 1'b0;
    latch_d = 1'b0;
    data_d  = 1'b0;
    done_d  = 1'b0;
`ifdef CFG_READBACK_EN
    cap_d      = cap_q;
    rd_idx_d   = rd_idx_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_fire) begin
          buf_d[count_q[IDX_W-1:0]] = wr_data;
          count_d = count_q + CNT_W'(1);
        end else if (start && (count_q == CNT_W'(NUM_WORDS))) begin
          state_d = SHIFT;
          bit_d   = '0;
          shift_d = 1'b1;
          data_d  = img[CHAIN_LEN-1];
        end
      end
      SHIFT: begin
`ifdef CFG_READBACK_EN
        cap_d = {cap_q[CHAIN_LEN-2:0], cfg_in.data};
`endif
        if (bit_q == BIT_W'(CHAIN_LEN-1)) begin
          state_d = LATCH;
          bit_d   = '0;
          latch_d = 1'b1;
        end else begin
          bit_d   = bit_q + BIT_W'(1);
          shift_d = 1'b1;
          // Output register holds the bit for the upcoming cycle (index bit_q+1).
          data_d  = img[BIT_W'(CHAIN_LEN-2) - bit_q];
        end
      end
      LATCH: begin
`ifdef CFG_READBACK_EN
        state_d    = DRAIN;
        rd_idx_d   = '0;
        rd_valid_d = 1'b1;
        rd_data_d  = word_of(cap_q, '0);
`else
        state_d = IDLE;
        done_d  = 1'b1;
        count_d = '0;
`endif
      end
`ifdef CFG_READBACK_EN
      DRAIN: begin
        if (rd_ready) begin
          if (rd_idx_q == IDX_W'(NUM_WORDS-1)) begin
            state_d    = IDLE;
            count_d    = '0;
            rd_valid_d = 1'b0;
            rd_data_d  = '0;
          end else begin
            rd_idx_d  = rd_idx_q + IDX_W'(1);
            rd_data_d = word_of(cap_q, rd_idx_q + IDX_W'(1));
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    wr_ready_d = (state_d == IDLE) && (count_d < CNT_W'(NUM_WORDS));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      bit_q      <= '0;
      for (int unsigned w = 0; w < NUM_WORDS; w++) buf_q[w] <= '0;
      shift_q    <= 1'b0;
      latch_q    <= 1'b0;
      data_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      bit_q      <= bit_d;
      buf_q      <= buf_d;
      shift_q    <= shift_d;
      latch_q    <= latch_d;
      data_q     <= data_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      wr_ready_q <= wr_ready_d;
    end
  end

`ifdef CFG_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q      <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      cap_q      <= cap_d;
      rd_idx_q   <= rd_idx_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  // done marks acceptance of the last word, so it follows rd_ready in that cycle.
  assign done     = done_q | (rd_valid_q & rd_ready & (rd_idx_q == IDX_W'(NUM_WORDS-1)));
`else
  logic unused_rb;
  assign unused_rb = cfg_in.data ^ rd_ready;
  assign rd_valid  = 1'b0;
  assign rd_data   = '0;
  assign done      = done_q;
`endif

  assign wr_ready      = wr_ready_q;
  assign busy          = busy_q;
  assign cfg_out.data  = data_q;
  assign cfg_out.shift = shift_q;
  assign cfg_out.latch = latch_q;

endmodule

// File: tb/tb_cfg_chain_master.sv
// Directed bench for cfg_chain_master (WORD_W=16, NUM_WORDS=4). A 64-bit
// shift register models the chain between cfg_out and cfg_in.
module tb_cfg_chain_master;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned CHAIN_LEN = 64;

  logic              clk = 1'b0;
  logic              reset, wr_valid, wr_ready, start, busy, done, rd_valid, rd_ready;
  logic [WORD_W-1:0] wr_data, rd_data;
  logic [CHAIN_LEN-1:0] chain = '0;

  int n_checks = 0;
  int n_fail   = 0;

  config_if head ();
  config_if tail ();

  always #5 clk = ~clk;

  assign tail.data  = chain[CHAIN_LEN-1];
  assign tail.shift = 1'b0;
  assign tail.latch = 1'b0;

  // Chain model; cleared by reset so each section starts from a known image.
  always @(posedge clk) begin
    if (reset) chain <= '0;
    else if (head.shift) chain <= {chain[CHAIN_LEN-2:0], head.data};
  end

  cfg_chain_master #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .cfg_out  (head.master),
    .cfg_in   (tail.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input logic [63:0] img, input int n);
    for (int w = 0; w < n; w++) begin
      wr_valid = 1'b1;
      wr_data  = img[63-16*w -: 16];
      tick();
    end
    wr_valid = 1'b0;
  endtask

  // Full transaction on a buffered image; returns the readback stream.
  task automatic run_txn(input logic [63:0] img, input int stall_word, output logic [63:0] rb);
    logic [63:0] seen;
    logic [15:0] held;
    int nshift;
    seen   = '0;
    nshift = 0;
    rb     = '0;
    held   = '0;
    start = 1'b1;
    tick();
    chk("busy_at_t1", 64'(busy), 64'(1));
    chk("wr_ready_at_t1", 64'(wr_ready), 64'(0));
    for (int i = 0; i < 64; i++) begin
      if (head.shift) nshift++;
      seen  = {seen[62:0], head.data};
      start = (i == 10);
      tick();
    end
    start = 1'b0;
    chk("shift_count", 64'(nshift), 64'(64));
    chk("shift_data", seen, img);
    chk("latch_cycle", 64'({head.latch, head.shift, head.data, busy}), 64'(4'b1001));
    tick();
    chk("latch_one_cycle", 64'(head.latch), 64'(0));
`ifdef CFG_READBACK_EN
    for (int w = 0; w < 4; w++) begin
      chk("rd_valid_drain", 64'(rd_valid), 64'(1));
      if (w == stall_word) begin
        rd_ready = 1'b0;
        held     = rd_data;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("rd_hold", 64'({rd_valid, done, rd_data}), 64'({1'b1, 1'b0, held}));
        end
        rd_ready = 1'b1;
      end
      chk("done_on_last", 64'(done), 64'(w == 3));
      rb = {rb[47:0], rd_data};
      tick();
    end
    chk("after_drain", 64'({rd_valid, busy, wr_ready, done}), 64'(4'b0010));
`else
    chk("done_no_rb", 64'({done, busy, rd_valid, wr_ready}), 64'(4'b1001));
    chk("rd_data_zero", 64'(rd_data), 64'(0));
    tick();
    chk("done_pulse", 64'(done), 64'(0));
`endif
    chk("no_restart", 64'(head.shift), 64'(0));
  endtask

  logic [63:0] img0, img_a, img_b, rb;
  int          cnt;

  initial begin
    img0  = 64'hA5A5_0001_8000_FFFF;
    img_a = 64'h1234_5678_9ABC_DEF0;
    img_b = 64'h1111_2222_3333_4444;
    reset = 1'b1; wr_valid = 1'b0; wr_data = '0; start = 1'b0; rd_ready = 1'b1;
    tick();
    tick();
    chk("reset_outputs", 64'({wr_ready, busy, head.shift, head.latch, head.data, rd_valid, done}),
        64'(7'b1000000));
    reset = 1'b0;
    tick();
    chk("idle_outputs", 64'({wr_ready, busy, head.shift, head.latch, rd_valid, done}),
        64'(6'b100000));

    // Start with an empty buffer is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (head.shift || busy) cnt++;
      tick();
    end
    chk("empty_start", 64'(cnt), 64'(0));

    // Fill, then attempt an overflow write.
    write_words(img0, 4);
    chk("full_wr_ready", 64'(wr_ready), 64'(0));
    wr_valid = 1'b1; wr_data = 16'h1234;
    tick();
    wr_valid = 1'b0;
    chk("overflow_idle", 64'({wr_ready, busy}), 64'(0));
    run_txn(img0, 9, rb);
`ifdef CFG_READBACK_EN
    chk("rb_first", rb, 64'h0);
`endif

    // Fresh chain, then write+start together with 3 words buffered.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    write_words(img_a, 3);
    chk("three_words_ready", 64'(wr_ready), 64'(1));
    wr_valid = 1'b1; wr_data = img_a[15:0]; start = 1'b1;
    tick();
    wr_valid = 1'b0; start = 1'b0;
    chk("simul_no_shift", 64'({head.shift, busy, wr_ready}), 64'(0));
    tick();
    chk("simul_still_idle", 64'({head.shift, busy}), 64'(0));
    run_txn(img_a, 9, rb);
`ifdef CFG_READBACK_EN
    chk("rb_a", rb, 64'h0);
`endif

    write_words(img_b, 4);
    run_txn(img_b, 1, rb);
`ifdef CFG_READBACK_EN
    chk("rb_b", rb, img_a);
`endif

    // Reset in the middle of a shift.
    write_words(img_a, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    chk("mid_shift_active", 64'(head.shift), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_shift", 64'({head.shift, head.latch, rd_valid, done, wr_ready, busy}),
        64'(6'b000010));
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (head.latch || head.shift) cnt++;
      tick();
    end
    chk("no_latch_after_reset", 64'(cnt), 64'(0));
    write_words(img_b, 3);
    chk("count_cleared", 64'(wr_ready), 64'(1));
    write_words(img_b, 1);
    chk("count_full_again", 64'(wr_ready), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
